// File: rtl/control_sequencer.sv
// Control sequencer for the 12-bit microcontroller: owns LOAD/FETCH/DECODE/EXECUTE/HALT
// sequencing and decodes the instruction into datapath enables, selects and ALU mode.
module control_sequencer #(
  parameter int INSTR_W    = 12,
  parameter int ALU_MODE_W = 4,
  parameter int FLAG_W     = 4,
  parameter int PROG_DEPTH = 256,
  parameter int MAX_WAIT   = 15,
  localparam int ADDR_W    = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [INSTR_W-1:0]    Instr_Reg,
  input  logic [FLAG_W-1:0]     Status_Reg,
  input  logic                  DataMem_Ready,
  input  logic                  Resume,
  output logic                  ProgCounter_En,
  output logic                  Acc_En,
  output logic                  StatusReg_En,
  output logic                  InstrReg_En,
  output logic                  ProgMem_En,
  output logic                  ProgMemLoad_En,
  output logic                  DataMemWrite_En,
  output logic                  ALU_En,
  output logic                  MUX1_Sel,
  output logic                  MUX2_Sel,
  output logic                  DataMem_En,
  output logic                  DataReg_En,
  output logic [ALU_MODE_W-1:0] ALU_Mode,
  output logic [ADDR_W-1:0]     Load_Addr,
  output logic [2:0]            State,
  output logic                  Halted,
  output logic                  Mem_Error
);

  localparam int T      = INSTR_W - 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_FETCH   = 3'b010,
    S_DECODE  = 3'b011,
    S_EXECUTE = 3'b100,
    S_HALT    = 3'b101
  } state_t;

  state_t            cur_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        flags;
  logic              is_itype;
  logic              is_jump;
  logic              is_mtype;
  logic              is_halt;
  logic              unused_instr;

  assign is_itype     = Instr_Reg[T];
  assign is_jump      = (Instr_Reg[T:T-1] == 2'b01);
  assign is_mtype     = (Instr_Reg[T:T-2] == 3'b001);
  assign is_halt      = (Instr_Reg[T:T-3] == 4'b0001);
  assign flags        = 4'(Status_Reg);
  assign unused_instr = ^Instr_Reg;
  assign State        = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      Load_Addr <= '0;
      wait_cnt  <= '0;
      Mem_Error <= 1'b0;
    end else begin
      case (cur_state)
        S_IDLE: if (Start) cur_state <= S_LOAD;
        S_LOAD: begin
          if (Load_Addr == ADDR_W'(PROG_DEPTH - 1)) begin
            Load_Addr <= '0;
            cur_state <= S_FETCH;
          end else begin
            Load_Addr <= Load_Addr + ADDR_W'(1);
          end
        end
        S_FETCH: cur_state <= S_DECODE;
        S_DECODE: begin
          // Ready takes priority over a timeout landing in the same cycle
          if (is_mtype && !DataMem_Ready) begin
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
              wait_cnt  <= '0;
              Mem_Error <= 1'b1;
              cur_state <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt  <= '0;
            cur_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: cur_state <= is_halt ? S_HALT : S_FETCH;
        S_HALT:    if (Resume) cur_state <= S_FETCH;
        default:   cur_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ProgCounter_En  = 1'b0;
    Acc_En          = 1'b0;
    StatusReg_En    = 1'b0;
    InstrReg_En     = 1'b0;
    ProgMem_En      = 1'b0;
    ProgMemLoad_En  = 1'b0;
    DataMemWrite_En = 1'b0;
    ALU_En          = 1'b0;
    MUX1_Sel        = 1'b0;
    MUX2_Sel        = 1'b0;
    DataMem_En      = 1'b0;
    DataReg_En      = 1'b0;
    ALU_Mode        = '0;
    Halted          = 1'b0;
    case (cur_state)
      S_LOAD: begin
        ProgMemLoad_En = 1'b1;
        ProgMem_En     = 1'b1;
      end
      S_FETCH: begin
        InstrReg_En = 1'b1;
        ProgMem_En  = 1'b1;
      end
      S_DECODE: begin
        DataMem_En = is_mtype;
        DataReg_En = is_mtype;
      end
      S_EXECUTE: begin
        if (is_itype) begin
          ProgCounter_En = 1'b1;
          Acc_En         = 1'b1;
          StatusReg_En   = 1'b1;
          ALU_En         = 1'b1;
          MUX1_Sel       = 1'b1;
          ALU_Mode       = ALU_MODE_W'(Instr_Reg[T-1:T-3]);
        end else if (is_jump) begin
          // A set flag selects the sequential PC, a clear flag the jump target
          ProgCounter_En = 1'b1;
          MUX1_Sel       = flags[Instr_Reg[T-2:T-3]];
        end else if (is_mtype) begin
          ProgCounter_En  = 1'b1;
          StatusReg_En    = 1'b1;
          ALU_En          = 1'b1;
          MUX1_Sel        = 1'b1;
          MUX2_Sel        = 1'b1;
          Acc_En          = Instr_Reg[T-3];
          DataMem_En      = !Instr_Reg[T-3];
          DataReg_En      = !Instr_Reg[T-3];
          DataMemWrite_En = !Instr_Reg[T-3];
          ALU_Mode        = Instr_Reg[T-4 -: ALU_MODE_W];
        end else if (!is_halt) begin
          ProgCounter_En = 1'b1;
          MUX1_Sel       = 1'b1;
        end
      end
      S_HALT: begin
        Halted         = 1'b1;
        ProgCounter_En = Resume;
        MUX1_Sel       = Resume;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected output snapshots are queued as stimulus
// is applied and compared against the DUT outputs cycle by cycle.
module tb_control_sequencer;

  localparam int INSTR_W = 12;
  localparam int AMW     = 4;
  localparam int FW      = 4;
  localparam int DEPTH   = 4;
  localparam int MAXW    = 15;
  localparam int AW      = $clog2(DEPTH);
  localparam int SW      = 3 + 2 + 12 + AMW + AW;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_FETCH = 3'd2,
                         ST_DEC = 3'd3, ST_EXE = 3'd4, ST_HALT = 3'd5;

  localparam logic [11:0] PC = 12'h800, ACC = 12'h400, SRE = 12'h200, IRE = 12'h100,
                          PM = 12'h080, PML = 12'h040, DMW = 12'h020, ALUE = 12'h010,
                          M1 = 12'h008, M2 = 12'h004, DME = 12'h002, DRE = 12'h001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               Start = 1'b0;
  logic [INSTR_W-1:0] Instr_Reg = '0;
  logic [FW-1:0]      Status_Reg = '0;
  logic               DataMem_Ready = 1'b0;
  logic               Resume = 1'b0;
  logic ProgCounter_En, Acc_En, StatusReg_En, InstrReg_En, ProgMem_En, ProgMemLoad_En;
  logic DataMemWrite_En, ALU_En, MUX1_Sel, MUX2_Sel, DataMem_En, DataReg_En;
  logic [AMW-1:0]     ALU_Mode;
  logic [AW-1:0]      Load_Addr;
  logic [2:0]         State;
  logic               Halted;
  logic               Mem_Error;

  control_sequencer #(
    .INSTR_W(INSTR_W), .ALU_MODE_W(AMW), .FLAG_W(FW), .PROG_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Instr_Reg(Instr_Reg), .Status_Reg(Status_Reg),
    .DataMem_Ready(DataMem_Ready), .Resume(Resume),
    .ProgCounter_En(ProgCounter_En), .Acc_En(Acc_En), .StatusReg_En(StatusReg_En),
    .InstrReg_En(InstrReg_En), .ProgMem_En(ProgMem_En), .ProgMemLoad_En(ProgMemLoad_En),
    .DataMemWrite_En(DataMemWrite_En), .ALU_En(ALU_En), .MUX1_Sel(MUX1_Sel),
    .MUX2_Sel(MUX2_Sel), .DataMem_En(DataMem_En), .DataReg_En(DataReg_En),
    .ALU_Mode(ALU_Mode), .Load_Addr(Load_Addr), .State(State), .Halted(Halted),
    .Mem_Error(Mem_Error)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] obs;
  assign obs = {State, Halted, Mem_Error,
                ProgCounter_En, Acc_En, StatusReg_En, InstrReg_En, ProgMem_En, ProgMemLoad_En,
                DataMemWrite_En, ALU_En, MUX1_Sel, MUX2_Sel, DataMem_En, DataReg_En,
                ALU_Mode, Load_Addr};

  logic [SW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [SW-1:0] mk(input logic [2:0] st, input logic [11:0] en,
                                        input logic [AMW-1:0] alu, input logic [AW-1:0] la,
                                        input logic h, input logic me);
    return {st, h, me, en, alu, la};
  endfunction

  task automatic push(input string t, input logic [SW-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic cmp_next();
    logic [SW-1:0] e;
    string         t;
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string t, input logic [SW-1:0] v);
    push(t, v);
    cmp_next();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH and DECODE for a non-M instruction, leaving the DUT in EXECUTE
  task automatic fetch_decode(input logic [INSTR_W-1:0] ir, input logic me);
    Instr_Reg = ir;
    chk("fetch", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, me));
    tick();
    chk("decode", mk(ST_DEC, 12'h000, '0, '0, 1'b0, me));
    tick();
  endtask

  initial begin
    // Reset held
    @(posedge clk); #1;
    chk("reset_state", mk(ST_IDLE, 12'h000, '0, '0, 1'b0, 1'b0));
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", mk(ST_IDLE, 12'h000, '0, '0, 1'b0, 1'b0));
    Start = 1'b1;
    chk("idle_start", mk(ST_IDLE, 12'h000, '0, '0, 1'b0, 1'b0));
    tick();
    Start = 1'b0;

    // Program load: DEPTH cycles with incrementing address
    for (int i = 0; i < DEPTH; i++) push("load", mk(ST_LOAD, PM | PML, '0, AW'(i), 1'b0, 1'b0));
    for (int i = 0; i < DEPTH; i++) begin
      cmp_next();
      tick();
    end

    // I-type instructions
    fetch_decode(12'h8A3, 1'b0);
    chk("itype_exec_8A3", mk(ST_EXE, PC | ACC | SRE | ALUE | M1, 4'h0, '0, 1'b0, 1'b0));
    tick();
    fetch_decode(12'hD00, 1'b0);
    chk("itype_exec_D00", mk(ST_EXE, PC | ACC | SRE | ALUE | M1, 4'h5, '0, 1'b0, 1'b0));
    tick();

    // Jump on Status_Reg[1]
    Status_Reg = 4'b0010;
    fetch_decode(12'h570, 1'b0);
    chk("jump_flag_set", mk(ST_EXE, PC | M1, '0, '0, 1'b0, 1'b0));
    Status_Reg = 4'b0000;
    chk("jump_flag_clr", mk(ST_EXE, PC, '0, '0, 1'b0, 1'b0));
    Status_Reg = 4'b1101;
    chk("jump_other_flags", mk(ST_EXE, PC, '0, '0, 1'b0, 1'b0));
    tick();

    // M-type store, Ready after 3 waiting cycles
    Instr_Reg = 12'h2C0;
    chk("mstore_fetch", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, 1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("mstore_wait", mk(ST_DEC, DME | DRE, '0, '0, 1'b0, 1'b0));
      tick();
    end
    DataMem_Ready = 1'b1;
    chk("mstore_ready", mk(ST_DEC, DME | DRE, '0, '0, 1'b0, 1'b0));
    tick();
    DataMem_Ready = 1'b0;
    chk("mstore_exec", mk(ST_EXE, PC | SRE | ALUE | M1 | M2 | DME | DRE | DMW, 4'hC, '0, 1'b0, 1'b0));
    tick();

    // M-type load, Ready immediately
    Instr_Reg = 12'h3A0;
    DataMem_Ready = 1'b1;
    chk("mload_fetch", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, 1'b0));
    tick();
    chk("mload_decode", mk(ST_DEC, DME | DRE, '0, '0, 1'b0, 1'b0));
    tick();
    DataMem_Ready = 1'b0;
    chk("mload_exec", mk(ST_EXE, PC | SRE | ALUE | M1 | M2 | ACC, 4'hA, '0, 1'b0, 1'b0));
    tick();

    // NOP
    fetch_decode(12'h0A5, 1'b0);
    chk("nop_exec", mk(ST_EXE, PC | M1, '0, '0, 1'b0, 1'b0));
    tick();

    // Ready arriving on the last permitted wait cycle beats the timeout
    Instr_Reg = 12'h2C0;
    chk("edge_fetch", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, 1'b0));
    tick();
    for (int i = 0; i < MAXW; i++) begin
      DataMem_Ready = (i == MAXW - 1);
      chk("edge_decode", mk(ST_DEC, DME | DRE, '0, '0, 1'b0, 1'b0));
      tick();
    end
    DataMem_Ready = 1'b0;
    chk("edge_exec_no_error", mk(ST_EXE, PC | SRE | ALUE | M1 | M2 | DME | DRE | DMW, 4'hC, '0, 1'b0, 1'b0));
    tick();

    // Timeout: Ready never arrives
    chk("tmo_fetch", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, 1'b0));
    tick();
    for (int i = 0; i < MAXW; i++) begin
      chk("tmo_decode", mk(ST_DEC, DME | DRE, '0, '0, 1'b0, 1'b0));
      tick();
    end
    chk("tmo_halt", mk(ST_HALT, 12'h000, '0, '0, 1'b1, 1'b1));
    tick();
    chk("halt_hold", mk(ST_HALT, 12'h000, '0, '0, 1'b1, 1'b1));
    Resume = 1'b1;
    chk("halt_resume", mk(ST_HALT, PC | M1, '0, '0, 1'b1, 1'b1));
    tick();
    Resume = 1'b0;
    Instr_Reg = 12'h100;
    chk("resume_fetch_sticky", mk(ST_FETCH, IRE | PM, '0, '0, 1'b0, 1'b1));
    tick();

    // HALT instruction, then asynchronous reset mid-HALT
    chk("hlt_decode", mk(ST_DEC, 12'h000, '0, '0, 1'b0, 1'b1));
    tick();
    chk("hlt_exec", mk(ST_EXE, 12'h000, '0, '0, 1'b0, 1'b1));
    tick();
    chk("hlt_state", mk(ST_HALT, 12'h000, '0, '0, 1'b1, 1'b1));
    tick();
    Resume = 1'b1;
    #1;
    rst_n = 1'b0;
    chk("async_reset", mk(ST_IDLE, 12'h000, '0, '0, 1'b0, 1'b0));
    Resume = 1'b0;
    tick();
    chk("reset_held", mk(ST_IDLE, 12'h000, '0, '0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor to the 12-bit microcontroller's combinational control decoder.
- Owns the LOAD/FETCH/DECODE/EXECUTE state machine internally, so no external state input is needed.
- Adds an idle/start handshake, a counted program-load phase, data-memory ready handshaking with timeout, and an explicit HALT state with resume.
- Sits between the instruction register, status register and the datapath enables (PC, accumulator, ALU, muxes, data memory).

Parameters:
- INSTR_W, 12, instruction width (>= 8).
- ALU_MODE_W, 4, ALU mode bus width.
- FLAG_W, 4, status flag count (power of 2, <= 4).
- PROG_DEPTH, 256, program words written during LOAD.
- MAX_WAIT, 15, max DECODE cycles waiting for DataMem_Ready before error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  leaves IDLE, begins LOAD.
- Instr_Reg  in  INSTR_W  current instruction.
- Status_Reg  in  FLAG_W  ALU flags (Z,C,S,O at indices 0..3).
- DataMem_Ready  in  1  data memory read data valid.
- Resume  in  1  exits HALT.
- ProgCounter_En, Acc_En, StatusReg_En, InstrReg_En, ProgMem_En, ProgMemLoad_En, DataMemWrite_En, ALU_En, MUX1_Sel, MUX2_Sel, DataMem_En, DataReg_En  out  1 each  datapath enables/selects.
- ALU_Mode  out  ALU_MODE_W  ALU operation.
- Load_Addr  out  clog2(PROG_DEPTH)  program memory write address during LOAD.
- State  out  3  IDLE=000 LOAD=001 FETCH=010 DECODE=011 EXECUTE=100 HALT=101.
- Halted  out  1  high in HALT.
- Mem_Error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; Load_Addr=0; wait counter=0; Mem_Error=0.
  - All enables, selects and ALU_Mode are 0. This also holds mid-operation.
- Outputs are combinational from registered state, Instr_Reg, Status_Reg and the handshake inputs. Any output not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Start=1 -> LOAD next cycle; otherwise stay.
- LOAD:
  - ProgMemLoad_En=1, ProgMem_En=1.
  - Load_Addr increments each cycle.
  - When Load_Addr==PROG_DEPTH-1: Load_Addr wraps to 0 and the next state is FETCH.
  - LOAD lasts exactly PROG_DEPTH cycles.
- FETCH:
  - InstrReg_En=1, ProgMem_En=1.
  - Next state is DECODE.
- Instruction field names (T = INSTR_W-1):
  - I-type: IR[T]=1.
  - Jump: IR[T:T-1]=01.
  - M-type: IR[T:T-2]=001.
  - NOP: IR[T:T-3]=0000.
  - HALT: IR[T:T-3]=0001.
- DECODE, M-type:
  - DataMem_En=1, DataReg_En=1.
  - Stay in DECODE until DataMem_Ready=1, then EXECUTE next cycle.
  - The wait counter increments per waiting cycle. If it reaches MAX_WAIT with Ready still 0: set Mem_Error and go to HALT.
  - The counter clears on leaving DECODE.
- DECODE, non-M-type: one cycle, no enables, then EXECUTE.
- EXECUTE, I-type:
  - ProgCounter_En, Acc_En, StatusReg_En, ALU_En, MUX1_Sel = 1.
  - ALU_Mode = zero-extended IR[T-1:T-3].
  - Next state FETCH.
- EXECUTE, Jump:
  - ProgCounter_En=1.
  - MUX1_Sel = Status_Reg[IR[T-2:T-3]], i.e. flag clear -> jump target, flag set -> sequential.
  - Next state FETCH.
- EXECUTE, M-type:
  - ProgCounter_En, StatusReg_En, ALU_En, MUX1_Sel, MUX2_Sel = 1.
  - Acc_En = IR[T-3].
  - DataMem_En = DataReg_En = DataMemWrite_En = !IR[T-3].
  - ALU_Mode = IR[T-4:T-3-ALU_MODE_W].
  - Next state FETCH.
- EXECUTE, NOP: ProgCounter_En=1, MUX1_Sel=1, then FETCH.
- EXECUTE, HALT: all enables 0; next state HALT.
- HALT:
  - Halted=1.
  - Resume=1 that cycle: ProgCounter_En=1, MUX1_Sel=1 (step past HALT), then FETCH. Mem_Error stays set.
  - Otherwise stay in HALT.
- Start is ignored outside IDLE. Resume is ignored outside HALT.
- Ready=1 and timeout in the same cycle: Ready wins.

Test Plan:
- PROG_DEPTH=4, rst_n released, Start pulse -> exactly 4 LOAD cycles with Load_Addr 0,1,2,3; ProgMemLoad_En=1 throughout; then State=FETCH with InstrReg_En=1.
- Instr_Reg=12'h8A3 (I-type) -> FETCH, DECODE, EXECUTE in 3 cycles; in EXECUTE ALU_Mode=4'h0 (IR[10:8]=000); Acc_En=StatusReg_En=ALU_En=MUX1_Sel=1; back to FETCH.
- Instr_Reg=12'h570 (jump on Status_Reg[1]):
  - Status_Reg=4'b0010 -> MUX1_Sel=1.
  - Status_Reg=4'b0000 -> MUX1_Sel=0.
  - ProgCounter_En=1 in both cases.
- Instr_Reg=12'h2C0 (M-type store), DataMem_Ready held 0 for 3 cycles then 1 -> 4 DECODE cycles with DataMem_En=1; then EXECUTE with DataMemWrite_En=1, Acc_En=0, ALU_Mode=4'hC.
- M-type with Ready never asserted, MAX_WAIT=15 -> Mem_Error=1 and State=HALT after 15 DECODE cycles; Resume pulse -> one cycle ProgCounter_En=1, then FETCH; Mem_Error still 1.
- Instr_Reg=12'h100 -> HALT state, Halted=1; rst_n asserted mid-HALT -> State=000 and all outputs 0 immediately, without waiting for a clock edge.
